// File: rtl/axi_pkg.sv
// Shared AXI write-arbitration types: one-hot grant encodings and write-channel FSM states.
// Pure types/constants; no latency or backpressure of its own.
package axi_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } aw_state_t;

  // M1 wins by default; force_m0 hands the grant to a requesting M0.
  function automatic logic [1:0] arb_pick(input logic req_m0, input logic req_m1,
                                          input logic force_m0);
    logic [1:0] pick;
    pick = GNT_NONE;
    if (req_m0 && (force_m0 || !req_m1)) begin
      pick = GNT_M0;
    end else if (req_m1) begin
      pick = GNT_M1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/aw_arbiter_if.sv
// Request/handshake bundle between two AXI write masters, the selected slave and the arbiter.
// Pure wiring; the arbiter side uses the slave modport.
interface aw_arbiter_if;

  logic       AWVALID_M0;
  logic       AWVALID_M1;
  logic       AWREADY_S;
  logic       WVALID_G;
  logic       WREADY_S;
  logic       WLAST_G;
  logic       BVALID_S;
  logic       BREADY_G;
  logic [1:0] gnt;
  logic       aw_en;
  logic       w_en;
  logic       b_en;
  logic       busy;

  modport master (
    output AWVALID_M0, AWVALID_M1, AWREADY_S, WVALID_G, WREADY_S, WLAST_G,
           BVALID_S, BREADY_G,
    input  gnt, aw_en, w_en, b_en, busy
  );

  modport slave (
    input  AWVALID_M0, AWVALID_M1, AWREADY_S, WVALID_G, WREADY_S, WLAST_G,
           BVALID_S, BREADY_G,
    output gnt, aw_en, w_en, b_en, busy
  );

endinterface

// File: rtl/aw_arbiter.sv
// Two-master AXI write arbiter, one write in flight: grant registered 1 cycle after request, held until B handshake.
// Phases stall on the AW/W/B handshakes; AW_ARB_STARVE_EN adds M0 starvation protection (STARVE_LIMIT losses).
module aw_arbiter
  import axi_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        ACLK,
  input  logic        ARESET,
  aw_arbiter_if.slave bus
);

  aw_state_t  state;
  aw_state_t  state_nxt;
  logic [1:0] gnt_q;
  logic [1:0] gnt_nxt;
  logic [1:0] winner;
  logic       req_any;
  logic       aw_hs;
  logic       w_done;
  logic       b_done;
  logic       force_m0;

  assign req_any = bus.AWVALID_M0 | bus.AWVALID_M1;
  // Only the granted master's AWVALID counts; the loser may toggle freely.
  assign aw_hs   = ((gnt_q[0] & bus.AWVALID_M0) | (gnt_q[1] & bus.AWVALID_M1)) & bus.AWREADY_S;
  assign w_done  = bus.WVALID_G & bus.WREADY_S & bus.WLAST_G;
  assign b_done  = bus.BVALID_S & bus.BREADY_G;

`ifdef AW_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign force_m0 = (starve_cnt == LIMIT);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && req_any) begin
      if (winner == GNT_M0) begin
        starve_cnt <= '0;
      end else if (bus.AWVALID_M0 && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign force_m0 = 1'b0;
`endif

  assign winner = arb_pick(bus.AWVALID_M0, bus.AWVALID_M1, force_m0);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= ST_IDLE;
      gnt_q <= GNT_NONE;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          state_nxt = ST_ADDR;
          gnt_nxt   = winner;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_done) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Re-arbitration waits for the first IDLE cycle.
        if (b_done) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = GNT_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = GNT_NONE;
      end
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.aw_en = (state == ST_ADDR);
  assign bus.w_en  = (state == ST_DATA);
  assign bus.b_en  = (state == ST_RESP);
  assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_aw_arbiter.sv
// Bench for aw_arbiter: directed scenarios with literal expectations, then random traffic against a
// transaction-level model (owner + handshakes completed) compared on every falling edge.
module tb_aw_arbiter;
  import axi_pkg::*;

  localparam int LIMIT = 2;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;

  aw_arbiter_if bus ();

  aw_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: owner -1 = nobody, 0 = M0, 1 = M1; phase = handshakes completed (AW, then W-last).
  int m_owner  = -1;
  int m_phase  = 0;
  int m_losses = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] v);
    {bus.AWVALID_M0, bus.AWVALID_M1, bus.AWREADY_S, bus.WVALID_G,
     bus.WREADY_S, bus.WLAST_G, bus.BVALID_S, bus.BREADY_G} = v;
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  always @(posedge ACLK) begin : model
    bit starve_hit;
    bit m0_turn;
    bit own_aw;
`ifdef AW_ARB_STARVE_EN
    starve_hit = (m_losses >= LIMIT);
`else
    starve_hit = 1'b0;
`endif
    if (ARESET) begin
      m_owner  = -1;
      m_phase  = 0;
      m_losses = 0;
    end else if (m_owner < 0) begin
      if (bus.AWVALID_M0 || bus.AWVALID_M1) begin
        m0_turn = bus.AWVALID_M0 && (!bus.AWVALID_M1 || starve_hit);
        if (m0_turn) begin
          m_owner  = 0;
          m_losses = 0;
        end else begin
          m_owner = 1;
          if (bus.AWVALID_M0 && m_losses < LIMIT) m_losses = m_losses + 1;
        end
        m_phase = 0;
      end
    end else if (m_phase == 0) begin
      own_aw = (m_owner == 0) ? bus.AWVALID_M0 : bus.AWVALID_M1;
      if (own_aw && bus.AWREADY_S) m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus.WVALID_G && bus.WREADY_S && bus.WLAST_G) m_phase = 2;
    end else begin
      if (bus.BVALID_S && bus.BREADY_G) begin
        m_owner = -1;
        m_phase = 0;
      end
    end
  end

  always @(negedge ACLK) begin
    if (chk_en) begin
      chk("gnt", int'(bus.gnt), (m_owner < 0) ? 0 : ((m_owner == 0) ? 1 : 2));
      chk("aw_en", int'(bus.aw_en), int'(m_owner >= 0 && m_phase == 0));
      chk("w_en", int'(bus.w_en), int'(m_owner >= 0 && m_phase == 1));
      chk("b_en", int'(bus.b_en), int'(m_owner >= 0 && m_phase == 2));
      chk("busy", int'(bus.busy), int'(m_owner >= 0));
`ifdef AW_ARB_STARVE_EN
      chk("starve_cnt", int'(dut.starve_cnt), m_losses);
`endif
    end
  end

  int seq[6];
  int exp_seq[6];
  int k;

  initial begin
    drive(8'h00);
    ARESET = 1'b1;
    cyc();
    cyc();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_en", int'({bus.aw_en, bus.w_en, bus.b_en}), 0);
    chk_en = 1'b1;
    ARESET = 1'b0;

    // Single M1 write through all phases.
    drive(8'b0100_0000); cyc();
    chk("m1_gnt", int'(bus.gnt), 2);
    chk("m1_aw_en", int'(bus.aw_en), 1);
    drive(8'b0110_0000); cyc();
    chk("m1_w_en", int'(bus.w_en), 1);
    drive(8'b0001_1100); cyc();
    chk("m1_b_en", int'(bus.b_en), 1);
    drive(8'b0000_0011); cyc();
    chk("m1_done_gnt", int'(bus.gnt), 0);
    chk("m1_done_busy", int'(bus.busy), 0);

    // Both request; M1 wins, grant sticks while requests change, M0 follows after IDLE.
    drive(8'b1100_0000); cyc();
    chk("both_gnt", int'(bus.gnt), 2);
    drive(8'b1110_0000); cyc();
    chk("both_w_en", int'(bus.w_en), 1);
    drive(8'b1000_0000); cyc();
    chk("hold_gnt", int'(bus.gnt), 2);
    chk("hold_w_en", int'(bus.w_en), 1);
    cyc();
    chk("hold_gnt2", int'(bus.gnt), 2);
    drive(8'b1001_1100); cyc();
    chk("both_b_en", int'(bus.b_en), 1);
    drive(8'b1000_0011); cyc();
    chk("no_same_cycle_gnt", int'(bus.gnt), 0);
    drive(8'b1000_0000); cyc();
    chk("m0_gnt", int'(bus.gnt), 1);

    // W-last beat during ADDR is ignored.
    drive(8'b1001_1100); cyc();
    chk("addr_w_ignored_aw", int'(bus.aw_en), 1);
    chk("addr_w_ignored_w", int'(bus.w_en), 0);
    drive(8'b1010_0000); cyc();
    chk("m0_w_en", int'(bus.w_en), 1);
    drive(8'b0001_1100); cyc();
    chk("m0_b_en", int'(bus.b_en), 1);

    // Reset while in RESP abandons the write.
    ARESET = 1'b1;
    drive(8'h00); cyc();
    ARESET = 1'b0;
    chk("resp_rst_gnt", int'(bus.gnt), 0);
    chk("resp_rst_en", int'({bus.aw_en, bus.w_en, bus.b_en, bus.busy}), 0);
`ifdef AW_ARB_STARVE_EN
    chk("resp_rst_starve", int'(dut.starve_cnt), 0);
`endif
    cyc();
    chk("post_rst_busy", int'(bus.busy), 0);

    // Continuous contention: grant order.
`ifdef AW_ARB_STARVE_EN
    exp_seq = '{2, 2, 1, 2, 2, 1};
`else
    exp_seq = '{2, 2, 2, 2, 2, 2};
`endif
    k = 0;
    drive(8'hFF);
    for (int n = 0; n < 40 && k < 6; n++) begin
      cyc();
      if (bus.aw_en) begin
        seq[k] = int'(bus.gnt);
        k++;
      end
    end
    drive(8'h00);
    if (k < 6) chk("grant_seq_timeout", k, 6);
    for (int i = 0; i < k; i++) chk("grant_seq", seq[i], exp_seq[i]);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      ARESET = ($urandom_range(99) == 0);
      drive(8'($urandom));
      cyc();
    end
    ARESET = 1'b0;
    drive(8'h00);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
